// File: rtl/game_state_controller.sv
`default_nettype none
// ============================================================================
//  Module   : game_state_controller
//  Purpose  : Frogger game sequencer - lives, respawn window, score/win and
//             frog facing direction.
//  Revision : 1.0 - initial release
// ============================================================================
module game_state_controller #(
   parameter int NUM_LIVES      = 3,
   parameter int NUM_SWITCHES   = 4,
   parameter int RESPAWN_CYCLES = 25000000,
   parameter int SCORE_WIDTH    = 4,
   parameter int MAX_SCORE      = 9
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst_L,
   input  logic [NUM_SWITCHES-1:0] i_Switch,
   input  logic                    i_Has_Collided,
   input  logic                    i_Level_Up,
   output logic [2:0]              o_State,
   output logic                    o_Game_Active,
   output logic [NUM_LIVES-1:0]    o_Lives,
   output logic [SCORE_WIDTH-1:0]  o_Score,
   output logic                    o_Respawn,
   output logic [1:0]              o_Frog_Direction,
   output logic                    o_Game_Over,
   output logic                    o_Win
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RUNNING   = 3'd1,
      ST_RESPAWN   = 3'd2,
      ST_GAME_OVER = 3'd3,
      ST_WIN       = 3'd4
   } state_t;

   localparam int                      c_TIMER_W      = $clog2(RESPAWN_CYCLES + 1);
   localparam logic [c_TIMER_W-1:0]    c_TIMER_LOAD   = c_TIMER_W'(RESPAWN_CYCLES - 1);
   localparam logic [c_TIMER_W-1:0]    c_TIMER_ZERO   = '0;
   localparam logic [c_TIMER_W-1:0]    c_TIMER_ONE    = c_TIMER_W'(1);
   localparam logic [NUM_LIVES-1:0]    c_LIVES_FULL   = '1;
   localparam logic [NUM_LIVES-1:0]    c_LIVES_LAST   = NUM_LIVES'(1);
   localparam logic [SCORE_WIDTH-1:0]  c_SCORE_ZERO   = '0;
   localparam logic [SCORE_WIDTH-1:0]  c_SCORE_ONE    = SCORE_WIDTH'(1);
   localparam logic [SCORE_WIDTH-1:0]  c_SCORE_WIN_M1 = SCORE_WIDTH'(MAX_SCORE - 1);

   localparam logic [1:0] c_DIR_UP    = 2'd0;
   localparam logic [1:0] c_DIR_LEFT  = 2'd1;
   localparam logic [1:0] c_DIR_RIGHT = 2'd2;
   localparam logic [1:0] c_DIR_DOWN  = 2'd3;

   // Registered state
   state_t                  r_state;
   logic [NUM_LIVES-1:0]    r_lives;
   logic [SCORE_WIDTH-1:0]  r_score;
   logic [c_TIMER_W-1:0]    r_timer;
   logic                    r_col_prev;
   logic                    r_respawn;
   logic [1:0]              r_dir;

   // Next-state values
   state_t                  w_state_next;
   logic [NUM_LIVES-1:0]    w_lives_next;
   logic [SCORE_WIDTH-1:0]  w_score_next;
   logic [c_TIMER_W-1:0]    w_timer_next;
   logic                    w_respawn_next;
   logic [1:0]              w_dir_next;

   logic                    w_all;
   logic                    w_none;
   logic                    w_col_edge;

   assign w_all      = &i_Switch[3:0];
   assign w_none     = ~|i_Switch[3:0];
   // A held collision level only produces one edge, so it costs one life.
   assign w_col_edge = i_Has_Collided & ~r_col_prev;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_state    <= ST_IDLE;
         r_lives    <= c_LIVES_FULL;
         r_score    <= c_SCORE_ZERO;
         r_timer    <= c_TIMER_ZERO;
         r_col_prev <= 1'b0;
         r_respawn  <= 1'b0;
         r_dir      <= c_DIR_UP;
      end else begin
         r_state    <= w_state_next;
         r_lives    <= w_lives_next;
         r_score    <= w_score_next;
         r_timer    <= w_timer_next;
         r_col_prev <= i_Has_Collided;
         r_respawn  <= w_respawn_next;
         r_dir      <= w_dir_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next   = r_state;
      w_lives_next   = r_lives;
      w_score_next   = r_score;
      w_timer_next   = r_timer;
      w_respawn_next = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_all) begin
               w_state_next = ST_RUNNING;
               w_lives_next = c_LIVES_FULL;
               w_score_next = c_SCORE_ZERO;
            end
         end

         ST_RUNNING: begin
            if (w_col_edge) begin
               if (r_lives == c_LIVES_LAST) begin
                  w_state_next = ST_GAME_OVER;
                  w_lives_next = '0;
               end else begin
                  w_state_next   = ST_RESPAWN;
                  w_lives_next   = r_lives >> 1;
                  w_timer_next   = c_TIMER_LOAD;
                  w_respawn_next = 1'b1;
               end
            end else if (i_Level_Up) begin
               w_score_next = r_score + c_SCORE_ONE;
               if (r_score == c_SCORE_WIN_M1) begin
                  w_state_next = ST_WIN;
               end
            end
         end

         // Invulnerable: collisions and level-ups are not looked at here.
         ST_RESPAWN: begin
            if (r_timer == c_TIMER_ZERO) begin
               w_state_next = ST_RUNNING;
            end else begin
               w_timer_next = r_timer - c_TIMER_ONE;
            end
         end

         ST_GAME_OVER, ST_WIN: begin
            if (w_none) begin
               w_state_next = ST_IDLE;
            end
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Frog direction: up > left > right > down, cleared on a hit when idle-handed
   // ------------------------------------------------------------------------
   always_comb begin
      w_dir_next = r_dir;
      if (i_Switch[0]) begin
         w_dir_next = c_DIR_UP;
      end else if (i_Switch[1]) begin
         w_dir_next = c_DIR_LEFT;
      end else if (i_Switch[2]) begin
         w_dir_next = c_DIR_RIGHT;
      end else if (i_Switch[3]) begin
         w_dir_next = c_DIR_DOWN;
      end else if (w_col_edge || r_respawn) begin
         w_dir_next = c_DIR_UP;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign o_State          = r_state;
   assign o_Lives          = r_lives;
   assign o_Score          = r_score;
   assign o_Respawn        = r_respawn;
   assign o_Frog_Direction = r_dir;
   assign o_Game_Active    = (r_state == ST_RUNNING);
   assign o_Game_Over      = (r_state == ST_GAME_OVER);
   assign o_Win            = (r_state == ST_WIN);

endmodule
`default_nettype wire

// File: tb/tb_game_state_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_state_controller
//  Purpose  : Scoreboard bench for game_state_controller with a count-based
//             reference model and randomized play.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_state_controller;

   localparam int c_LIVES   = 3;
   localparam int c_SW      = 4;
   localparam int c_RESPAWN = 4;
   localparam int c_SW_W    = 4;
   localparam int c_MAX     = 3;

   localparam int c_IDLE = 0, c_RUN = 1, c_RESP = 2, c_OVER = 3, c_WIN = 4;

   logic              i_Clk = 1'b0;
   logic              i_Rst_L = 1'b0;
   logic [c_SW-1:0]   i_Switch = '0;
   logic              i_Has_Collided = 1'b0;
   logic              i_Level_Up = 1'b0;
   logic [2:0]        o_State;
   logic              o_Game_Active;
   logic [c_LIVES-1:0] o_Lives;
   logic [c_SW_W-1:0] o_Score;
   logic              o_Respawn;
   logic [1:0]        o_Frog_Direction;
   logic              o_Game_Over;
   logic              o_Win;

   game_state_controller #(
      .NUM_LIVES      (c_LIVES),
      .NUM_SWITCHES   (c_SW),
      .RESPAWN_CYCLES (c_RESPAWN),
      .SCORE_WIDTH    (c_SW_W),
      .MAX_SCORE      (c_MAX)
   ) u_dut (
      .i_Clk            (i_Clk),
      .i_Rst_L          (i_Rst_L),
      .i_Switch         (i_Switch),
      .i_Has_Collided   (i_Has_Collided),
      .i_Level_Up       (i_Level_Up),
      .o_State          (o_State),
      .o_Game_Active    (o_Game_Active),
      .o_Lives          (o_Lives),
      .o_Score          (o_Score),
      .o_Respawn        (o_Respawn),
      .o_Frog_Direction (o_Frog_Direction),
      .o_Game_Over      (o_Game_Over),
      .o_Win            (o_Win)
   );

   always #5 i_Clk = ~i_Clk;

   typedef struct {
      int state;
      int active;
      int lives;
      int score;
      int respawn;
      int dir;
      int over;
      int win;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: lives as a plain count, respawn as cycles remaining.
   int m_state, m_lives, m_score, m_dir, m_left, m_pulse, m_prev;

   task automatic model_reset();
      m_state = c_IDLE; m_lives = c_LIVES; m_score = 0; m_dir = 0;
      m_left = 0; m_pulse = 0; m_prev = 0;
   endtask

   task automatic model_step(input logic [3:0] sw, input logic col, input logic lvl);
      int  d;
      bit  hit;
      int  pulse_now;
      hit       = col && !m_prev;
      pulse_now = m_pulse;
      m_pulse   = 0;
      d = -1;
      for (int b = 3; b >= 0; b--) if (sw[b]) d = b;
      if (d >= 0) m_dir = d;
      else if (hit || pulse_now != 0) m_dir = 0;
      case (m_state)
         c_IDLE: if (sw == 4'hF) begin m_state = c_RUN; m_lives = c_LIVES; m_score = 0; end
         c_RUN: begin
            if (hit) begin
               m_lives = m_lives - 1;
               if (m_lives == 0) m_state = c_OVER;
               else begin m_state = c_RESP; m_left = c_RESPAWN; m_pulse = 1; end
            end else if (lvl) begin
               m_score = m_score + 1;
               if (m_score == c_MAX) m_state = c_WIN;
            end
         end
         c_RESP: begin
            m_left = m_left - 1;
            if (m_left == 0) m_state = c_RUN;
         end
         default: if (sw == 4'h0) m_state = c_IDLE;
      endcase
      m_prev = col;
   endtask

   task automatic push_expect();
      exp_t e;
      e.state   = m_state;
      e.active  = (m_state == c_RUN);
      e.lives   = (1 << m_lives) - 1;
      e.score   = m_score;
      e.respawn = m_pulse;
      e.dir     = m_dir;
      e.over    = (m_state == c_OVER);
      e.win     = (m_state == c_WIN);
      sb.push_back(e);
   endtask

   // One stimulus cycle, driven at the falling edge; expectation queued.
   task automatic drive(input logic rst, input logic [3:0] sw, input logic col, input logic lvl);
      @(negedge i_Clk);
      if (!rst && i_Rst_L) begin
         model_reset();
         push_expect();
      end
      i_Rst_L        = rst;
      i_Switch       = sw;
      i_Has_Collided = col;
      i_Level_Up     = lvl;
      if (!rst) model_reset();
      else model_step(sw, col, lvl);
      push_expect();
   endtask

   task automatic idle_cycles(input int n, input logic col);
      for (int i = 0; i < n; i++) drive(1'b1, 4'h0, col, 1'b0);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Monitor: every clock edge (and an async reset assertion) presents outputs.
   initial begin
      exp_t e;
      forever begin
         @(posedge i_Clk or negedge i_Rst_L);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("state",     int'(o_State),          e.state);
            chk("active",    int'(o_Game_Active),    e.active);
            chk("lives",     int'(o_Lives),          e.lives);
            chk("score",     int'(o_Score),          e.score);
            chk("respawn",   int'(o_Respawn),        e.respawn);
            chk("direction", int'(o_Frog_Direction), e.dir);
            chk("game_over", int'(o_Game_Over),      e.over);
            chk("win",       int'(o_Win),            e.win);
         end
      end
   end

   initial begin
      model_reset();
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      idle_cycles(2, 1'b0);

      // Start
      drive(1'b1, 4'hF, 1'b0, 1'b0);
      idle_cycles(2, 1'b0);

      // Held collision: one life, four respawn cycles, no further loss
      idle_cycles(10, 1'b1);
      idle_cycles(2, 1'b0);

      // Pulses until game over, restart, then three more pulses from full
      for (int k = 0; k < 3; k++) begin
         idle_cycles(1, 1'b1);
         idle_cycles(6, 1'b0);
      end
      idle_cycles(2, 1'b0);
      drive(1'b1, 4'hF, 1'b0, 1'b0);
      idle_cycles(1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         idle_cycles(1, 1'b1);
         idle_cycles(6, 1'b0);
      end
      idle_cycles(1, 1'b0);

      // Win, then simultaneous level-up and collision edge
      drive(1'b1, 4'hF, 1'b0, 1'b0);
      idle_cycles(1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 4'h0, 1'b0, 1'b1);
         idle_cycles(1, 1'b0);
      end
      idle_cycles(1, 1'b0);
      drive(1'b1, 4'hF, 1'b0, 1'b0);
      idle_cycles(1, 1'b0);
      drive(1'b1, 4'h0, 1'b0, 1'b1);
      drive(1'b1, 4'h0, 1'b1, 1'b1);

      // Direction
      drive(1'b1, 4'b0110, 1'b0, 1'b0);
      drive(1'b1, 4'b1000, 1'b0, 1'b0);
      drive(1'b1, 4'b0000, 1'b1, 1'b0);
      idle_cycles(6, 1'b0);

      // Async reset two cycles into a respawn window
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      drive(1'b1, 4'hF, 1'b0, 1'b0);
      idle_cycles(1, 1'b0);
      drive(1'b1, 4'h0, 1'b1, 1'b0);
      idle_cycles(1, 1'b1);
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      idle_cycles(3, 1'b0);

      // Randomized play
      begin
         logic       col;
         logic [3:0] sw;
         int         r;
         col = 1'b0;
         for (int n = 0; n < 2500; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      sw = 4'hF;
            else if (r < 6) sw = 4'h0;
            else            sw = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) col = ~col;
            if ($urandom_range(0, 399) == 0) drive(1'b0, sw, col, 1'b0);
            else drive(1'b1, sw, col, ($urandom_range(0, 7) == 0));
         end
      end

      for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge i_Clk);
      #2;
      if (sb.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
Parametrised top-level game sequencer for the Frogger build. It generalises the current two-state IDLE/RUNNING life logic into a five-state machine: IDLE, RUNNING, RESPAWN, GAME_OVER, WIN. It adds a configurable life count, a timed respawn/invulnerability window, score tracking with a win condition, and frog-direction tracking. It sits between the debounce filters, collision detector and character control, and drives the LEDs, seven-segment score and sprite direction.

Parameters:
NUM_LIVES, 3, number of lives; width of the thermometer life vector (>=1)
NUM_SWITCHES, 4, number of debounced direction switches (>=4; bits 0..3 = up, left, right, down)
RESPAWN_CYCLES, 25000000, length of the RESPAWN window in clocks (>=1)
SCORE_WIDTH, 4, score register width
MAX_SCORE, 9, score value that triggers WIN (1..2^SCORE_WIDTH-1)

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  asynchronous, active-low reset
i_Switch  in  NUM_SWITCHES  debounced switches, active high
i_Has_Collided  in  1  collision level from the collision block
i_Level_Up  in  1  one-cycle pulse when the frog reaches the goal row
o_State  out  3  current state: IDLE=0, RUNNING=1, RESPAWN=2, GAME_OVER=3, WIN=4
o_Game_Active  out  1  high only in RUNNING
o_Lives  out  NUM_LIVES  thermometer count of remaining lives, LSB-aligned
o_Score  out  SCORE_WIDTH  current score
o_Respawn  out  1  one-cycle pulse on entry to RESPAWN; character control recentres the frog
o_Frog_Direction  out  2  0=up, 1=left, 2=right, 3=down
o_Game_Over  out  1  high in GAME_OVER
o_Win  out  1  high in WIN

Behaviour:
- Reset (asynchronous, active-low, may assert at any time including mid-RESPAWN):
  - State=IDLE, o_Lives=all ones, o_Score=0, o_Frog_Direction=0, o_Respawn=0.
  - Respawn timer=0, collision-tracking register=0.
  - Operation resumes on the first clock edge after release.
- w_All = AND of i_Switch[3:0].
- Collision edge: col_edge = i_Has_Collided & ~prev. prev is registered every cycle in every state. A collision held high therefore costs exactly one life.
- IDLE:
  - w_All=1 -> RUNNING next edge; o_Lives reloaded to all ones; o_Score=0.
- RUNNING:
  - col_edge with o_Lives==1 (last life) -> GAME_OVER; o_Lives=0.
  - col_edge otherwise -> RESPAWN; o_Lives shifts right by 1; timer loaded with RESPAWN_CYCLES-1; o_Respawn=1 for that one cycle.
  - i_Level_Up with no col_edge -> o_Score+1. If o_Score==MAX_SCORE-1 before the increment -> WIN.
  - Simultaneous col_edge and i_Level_Up: the collision takes priority and the score is unchanged.
- RESPAWN:
  - Collisions and level-ups are ignored (invulnerability).
  - Timer==0 -> RUNNING; otherwise the timer decrements. Dwell is exactly RESPAWN_CYCLES clocks.
  - Collision still high at exit does not cost a life, because prev=1. A new edge is required.
- GAME_OVER / WIN:
  - Lives and score are frozen for display.
  - Transition to IDLE once all of i_Switch[3:0] read 0. This forces release before a restart.
- Score: never wraps, because WIN is reached at MAX_SCORE. o_Score holds MAX_SCORE while in WIN.
- Frog direction, priority up > left > right > down:
  - Updated every cycle from i_Switch in all states.
  - With no switch pressed, it is cleared to 0 on col_edge or o_Respawn; otherwise it holds.
- Latency: all outputs are registered, except o_Game_Active, o_Game_Over and o_Win, which decode o_State combinationally. Every input takes effect in one cycle.
- Timer width: $clog2(RESPAWN_CYCLES+1). No other arithmetic may overflow.

Test Plan:
Bench parameters: NUM_LIVES=3, RESPAWN_CYCLES=4, MAX_SCORE=3.
1. Start: hold i_Switch=4'b1111 for 1 cycle in IDLE -> next edge o_State=1, o_Game_Active=1, o_Lives=3'b111, o_Score=0.
2. Respawn: in RUNNING, hold i_Has_Collided high for 10 cycles -> o_Lives=3'b011 (one decrement only), o_Respawn high 1 cycle, o_State=2 for exactly 4 cycles, then 1. No further decrement while the input stays high.
3. Game over: three separated collision pulses -> o_Lives 011, 001, 000. The third pulse goes straight to o_State=3 with o_Game_Over=1 and no RESPAWN. Switches 0 -> IDLE next edge. Switches 1111 -> RUNNING with o_Lives=111.
4. Win and priority: three i_Level_Up pulses -> o_Score 1, 2, 3; o_State=4 and o_Win=1 on the third. Separate run: i_Level_Up and a collision edge in the same cycle -> o_Lives decrements, o_Score unchanged, o_State=2.
5. Direction: i_Switch=0110 -> o_Frog_Direction=1. Then 1000 -> 3. Then 0000 with a collision edge -> 0.
6. Async reset in RESPAWN with timer=2: assert i_Rst_L=0 between clock edges -> outputs reset immediately (o_State=0, o_Lives=111, o_Score=0). After release with switches 0 -> stays IDLE.
